// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Control FSM for the multicycle RV32I datapath around a shared ALU.
//            Walks each instruction through IF/ID/EX/MEM/WB, drives the ALU
//            operand selects and operation, strobes IR/PC/RF/target writes,
//            and handshakes with instruction and data memory.
//            It halts on ECALL or on an unknown opcode.
// Options  : PERF_CNT_EN - adds the cycle_cnt / instret_cnt counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter logic [2:0]  RESET_STATE = 3'd0,
  parameter logic [31:0] ECALL_WORD  = 32'h0000_0073
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        alu_zero,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        tgt_we,
  output logic [1:0]  a_sel,
  output logic        b_sel,
  output logic        is_sign,
  output logic [4:0]  alu_control,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        halt,
  output logic        illegal,
  output logic [2:0]  state
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_JALR = 5'd9;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  // Registered state
  state_t state_q, state_d;
  logic   halt_q, halt_d;
  logic   illegal_q, illegal_d;

  // Ungated combinational strobes (forced low below while in reset)
  logic       imem_req_c, ir_we_c, pc_we_c, pc_sel_c, tgt_we_c;
  logic [1:0] a_sel_c;
  logic       b_sel_c, is_sign_c;
  logic [4:0] alu_c;
  logic       dmem_re_c, dmem_we_c, rf_we_c;
  logic [1:0] wb_sel_c;

  // Instruction fields and opcode classes
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic       is_load, is_store, is_opimm, is_op, is_known, is_ecall;
  logic       alt_mod;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_ecall  = (instr == ECALL_WORD);
  assign is_known  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                     is_load | is_store | is_opimm | is_op;

  // funct7[5] selects SUB/SRA; for immediates it is an imm bit except on shifts
  assign alt_mod = instr[30] & (is_op | (funct3 == 3'b101));

  // Per-state strobe decode and next-state selection
  always_comb begin
    state_d    = state_q;
    halt_d     = halt_q;
    illegal_d  = illegal_q;
    imem_req_c = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel_c   = 1'b0;
    tgt_we_c   = 1'b0;
    a_sel_c    = 2'd0;
    b_sel_c    = 1'b0;
    is_sign_c  = 1'b0;
    alu_c      = ALU_ADD;
    dmem_re_c  = 1'b0;
    dmem_we_c  = 1'b0;
    rf_we_c    = 1'b0;
    wb_sel_c   = WB_ALU;

    case (state_q)
      ST_IF: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_we_c = 1'b1;
          state_d = ST_ID;
        end
      end

      ST_ID: begin
        // Branch/JAL target PC+imm is computed here while decoding
        a_sel_c  = 2'd1;
        b_sel_c  = 1'b1;
        alu_c    = ALU_ADD;
        tgt_we_c = 1'b1;
        if (is_ecall) begin
          state_d = ST_HALT;
          halt_d  = 1'b1;
        end else if (is_jal | is_lui | is_auipc) begin
          state_d = ST_WB;
        end else if (is_known) begin
          state_d = ST_EX;
        end else begin
          state_d   = ST_HALT;
          halt_d    = 1'b1;
          illegal_d = 1'b1;
        end
      end

      ST_EX: begin
        if (is_op | is_opimm) begin
          b_sel_c = is_opimm;
          case (funct3)
            3'b000:  alu_c = alt_mod ? ALU_SUB : ALU_ADD;
            3'b001:  alu_c = ALU_SLL;
            3'b010:  begin alu_c = ALU_SLT; is_sign_c = 1'b1; end
            3'b011:  alu_c = ALU_SLT;
            3'b100:  alu_c = ALU_XOR;
            3'b101:  alu_c = alt_mod ? ALU_SRA : ALU_SRL;
            3'b110:  alu_c = ALU_OR;
            default: alu_c = ALU_AND;
          endcase
          state_d = ST_WB;
        end else if (is_load | is_store) begin
          b_sel_c = 1'b1;
          state_d = ST_MEM;
        end else if (is_branch) begin
          // SLT yields 1 (non-zero) when less-than, SUB yields 0 when equal
          pc_we_c = 1'b1;
          case (funct3)
            3'b000:  begin alu_c = ALU_SUB; pc_sel_c = alu_zero; end
            3'b001:  begin alu_c = ALU_SUB; pc_sel_c = ~alu_zero; end
            3'b100:  begin alu_c = ALU_SLT; is_sign_c = 1'b1; pc_sel_c = ~alu_zero; end
            3'b101:  begin alu_c = ALU_SLT; is_sign_c = 1'b1; pc_sel_c = alu_zero; end
            3'b110:  begin alu_c = ALU_SLT; pc_sel_c = ~alu_zero; end
            3'b111:  begin alu_c = ALU_SLT; pc_sel_c = alu_zero; end
            default: begin alu_c = ALU_SUB; pc_sel_c = 1'b0; end
          endcase
          state_d = ST_IF;
        end else if (is_jalr) begin
          b_sel_c  = 1'b1;
          alu_c    = ALU_JALR;
          tgt_we_c = 1'b1;
          state_d  = ST_WB;
        end else begin
          // Not reachable from ID; treat a corrupted IR as illegal
          state_d   = ST_HALT;
          halt_d    = 1'b1;
          illegal_d = 1'b1;
        end
      end

      ST_MEM: begin
        if (is_load) begin
          dmem_re_c = 1'b1;
          if (dmem_ready) state_d = ST_WB;
        end else begin
          dmem_we_c = 1'b1;
          if (dmem_ready) begin
            pc_we_c  = 1'b1;
            pc_sel_c = 1'b0;
            state_d  = ST_IF;
          end
        end
      end

      ST_WB: begin
        rf_we_c = 1'b1;
        pc_we_c = 1'b1;
        if (is_load) begin
          wb_sel_c = WB_LOAD;
        end else if (is_jal | is_jalr) begin
          wb_sel_c = WB_PC4;
          pc_sel_c = 1'b1;
        end else if (is_lui) begin
          a_sel_c = 2'd2;
          b_sel_c = 1'b1;
        end else if (is_auipc) begin
          a_sel_c = 2'd1;
          b_sel_c = 1'b1;
        end
        state_d = ST_IF;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        // Unused encodings recover to fetch
        state_d = ST_IF;
      end
    endcase
  end

  // State, halt and illegal registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= state_t'(RESET_STATE);
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
    end
  end

  // All outputs read as zero while reset is asserted
  assign imem_req    = RSTn & imem_req_c;
  assign ir_we       = RSTn & ir_we_c;
  assign pc_we       = RSTn & pc_we_c;
  assign pc_sel      = RSTn & pc_sel_c;
  assign tgt_we      = RSTn & tgt_we_c;
  assign a_sel       = RSTn ? a_sel_c : 2'd0;
  assign b_sel       = RSTn & b_sel_c;
  assign is_sign     = RSTn & is_sign_c;
  assign alu_control = RSTn ? alu_c : 5'd0;
  assign dmem_re     = RSTn & dmem_re_c;
  assign dmem_we     = RSTn & dmem_we_c;
  assign rf_we       = RSTn & rf_we_c;
  assign wb_sel      = RSTn ? wb_sel_c : 2'd0;
  assign halt        = RSTn & halt_q;
  assign illegal     = RSTn & illegal_q;
  assign state       = RSTn ? state_q : 3'd0;

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instret_cnt_q;

  // Free-running cycle and retired-instruction counters (wrap at 2^32)
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cycle_cnt_q   <= 32'd0;
      instret_cnt_q <= 32'd0;
    end else begin
      if (state_q != ST_HALT) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (pc_we_c)            instret_cnt_q <= instret_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt   = RSTn ? cycle_cnt_q : 32'd0;
  assign instret_cnt = RSTn ? instret_cnt_q : 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Scoreboard bench for multicycle_ctrl. Stimulus pushes one
//            hand-computed expected output vector per cycle; a monitor pops
//            and compares on every falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready, alu_zero;
  logic        imem_req, ir_we, pc_we, pc_sel, tgt_we;
  logic [1:0]  a_sel;
  logic        b_sel, is_sign;
  logic [4:0]  alu_control;
  logic        dmem_re, dmem_we, rf_we;
  logic [1:0]  wb_sel;
  logic        halt, illegal;
  logic [2:0]  state;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_ctrl dut (
    .CLK(CLK), .RSTn(RSTn), .instr(instr),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .alu_zero(alu_zero),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .tgt_we(tgt_we), .a_sel(a_sel), .b_sel(b_sel), .is_sign(is_sign),
    .alu_control(alu_control), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .rf_we(rf_we), .wb_sel(wb_sel), .halt(halt), .illegal(illegal),
    .state(state)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] state;
    logic       halt;
    logic       illegal;
    logic       imem_req;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel;
    logic       tgt_we;
    logic [1:0] a_sel;
    logic       b_sel;
    logic       is_sign;
    logic [4:0] alu;
    logic       dmem_re;
    logic       dmem_we;
    logic       rf_we;
    logic [1:0] wb_sel;
  } out_t;

  out_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    stim_done = 1'b0;

  function automatic out_t o_st(input logic [2:0] s);
    out_t e = '0;
    e.state = s;
    return e;
  endfunction

  function automatic out_t o_if(input logic rdy);
    out_t e = '0;
    e.imem_req = 1'b1;
    e.ir_we    = rdy;
    return e;
  endfunction

  function automatic out_t o_id();
    out_t e = o_st(3'd1);
    e.a_sel  = 2'd1;
    e.b_sel  = 1'b1;
    e.tgt_we = 1'b1;
    return e;
  endfunction

  function automatic out_t o_wb(input logic [1:0] ws, input logic ps);
    out_t e = o_st(3'd4);
    e.rf_we  = 1'b1;
    e.pc_we  = 1'b1;
    e.wb_sel = ws;
    e.pc_sel = ps;
    return e;
  endfunction

  // One clock cycle: drive inputs, queue the expected outputs, advance
  task automatic cyc(input logic imr, input logic dmr, input logic az,
                     input out_t e, input string nm);
    imem_ready = imr;
    dmem_ready = dmr;
    alu_zero   = az;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w, input string nm);
    instr = w;
    cyc(1'b1, 1'b1, 1'b0, o_if(1'b1), {nm, " IF"});
    cyc(1'b1, 1'b1, 1'b0, o_id(), {nm, " ID"});
  endtask

  // Stimulus
  initial begin : stim
    out_t e;
    RSTn = 1'b0; instr = 32'h0; imem_ready = 1'b1; dmem_ready = 1'b1; alu_zero = 1'b0;
    @(posedge CLK);
    #1;
    cyc(1, 1, 0, '0, "reset c0");
    cyc(1, 1, 0, '0, "reset c1");
    RSTn = 1'b1;

    // add x3,x1,x2
    fetch(32'h002081B3, "add");
    cyc(1, 1, 0, o_st(3'd2), "add EX");
    cyc(1, 1, 0, o_wb(2'd0, 1'b0), "add WB");

    // sub x3,x1,x2 with one fetch stall
    instr = 32'h402081B3;
    cyc(0, 1, 0, o_if(1'b0), "sub IF stall");
    fetch(32'h402081B3, "sub");
    e = o_st(3'd2); e.alu = 5'd1;
    cyc(1, 1, 0, e, "sub EX");
    cyc(1, 1, 0, o_wb(2'd0, 1'b0), "sub WB");

    // srai x1,x2,3
    fetch(32'h40315093, "srai");
    e = o_st(3'd2); e.b_sel = 1'b1; e.alu = 5'd7;
    cyc(1, 1, 0, e, "srai EX");
    cyc(1, 1, 0, o_wb(2'd0, 1'b0), "srai WB");

    // addi x1,x0,0x400: bit30 is an immediate bit, must stay ADD
    fetch(32'h40000093, "addi");
    e = o_st(3'd2); e.b_sel = 1'b1; e.alu = 5'd0;
    cyc(1, 1, 0, e, "addi EX");
    cyc(1, 1, 0, o_wb(2'd0, 1'b0), "addi WB");

    // slt / sltu
    fetch(32'h0020A1B3, "slt");
    e = o_st(3'd2); e.alu = 5'd8; e.is_sign = 1'b1;
    cyc(1, 1, 0, e, "slt EX");
    cyc(1, 1, 0, o_wb(2'd0, 1'b0), "slt WB");
    fetch(32'h0020B1B3, "sltu");
    e = o_st(3'd2); e.alu = 5'd8;
    cyc(1, 1, 0, e, "sltu EX");
    cyc(1, 1, 0, o_wb(2'd0, 1'b0), "sltu WB");

    // lw x5,0(x1) with 3 data wait cycles
    fetch(32'h0000A283, "lw");
    e = o_st(3'd2); e.b_sel = 1'b1;
    cyc(1, 1, 0, e, "lw EX");
    e = o_st(3'd3); e.dmem_re = 1'b1;
    cyc(1, 0, 0, e, "lw MEM w0");
    cyc(1, 0, 0, e, "lw MEM w1");
    cyc(1, 0, 0, e, "lw MEM w2");
    cyc(1, 1, 0, e, "lw MEM rdy");
    cyc(1, 1, 0, o_wb(2'd1, 1'b0), "lw WB");

    // beq taken / not taken
    fetch(32'h00208463, "beq t");
    e = o_st(3'd2); e.alu = 5'd1; e.pc_we = 1'b1; e.pc_sel = 1'b1;
    cyc(1, 1, 1, e, "beq taken EX");
    fetch(32'h00208463, "beq nt");
    e = o_st(3'd2); e.alu = 5'd1; e.pc_we = 1'b1;
    cyc(1, 1, 0, e, "beq not-taken EX");

    // blt taken (SLT result non-zero), bgeu taken (SLT result zero)
    fetch(32'h0020C463, "blt");
    e = o_st(3'd2); e.alu = 5'd8; e.is_sign = 1'b1; e.pc_we = 1'b1; e.pc_sel = 1'b1;
    cyc(1, 1, 0, e, "blt EX");
    fetch(32'h0020F463, "bgeu");
    e = o_st(3'd2); e.alu = 5'd8; e.pc_we = 1'b1; e.pc_sel = 1'b1;
    cyc(1, 1, 1, e, "bgeu EX");

    // jal x1,16
    fetch(32'h010000EF, "jal");
    cyc(1, 1, 0, o_wb(2'd2, 1'b1), "jal WB");

    // jalr x1,0(x2)
    fetch(32'h000100E7, "jalr");
    e = o_st(3'd2); e.b_sel = 1'b1; e.alu = 5'd9; e.tgt_we = 1'b1;
    cyc(1, 1, 0, e, "jalr EX");
    cyc(1, 1, 0, o_wb(2'd2, 1'b1), "jalr WB");

    // lui / auipc
    fetch(32'h123450B7, "lui");
    e = o_wb(2'd0, 1'b0); e.a_sel = 2'd2; e.b_sel = 1'b1;
    cyc(1, 1, 0, e, "lui WB");
    fetch(32'h00001097, "auipc");
    e = o_wb(2'd0, 1'b0); e.a_sel = 2'd1; e.b_sel = 1'b1;
    cyc(1, 1, 0, e, "auipc WB");

    // sw x5,4(x1) with one data wait cycle
    fetch(32'h0050A223, "sw");
    e = o_st(3'd2); e.b_sel = 1'b1;
    cyc(1, 1, 0, e, "sw EX");
    e = o_st(3'd3); e.dmem_we = 1'b1;
    cyc(1, 0, 0, e, "sw MEM wait");
    e.pc_we = 1'b1;
    cyc(1, 1, 0, e, "sw MEM rdy");

    // reset in the middle of an add aborts it
    fetch(32'h002081B3, "add2");
    RSTn = 1'b0;
    cyc(1, 1, 0, '0, "add2 abort reset");
    RSTn = 1'b1;

    // ecall halts; no further fetch
    fetch(32'h00000073, "ecall");
    e = o_st(3'd5); e.halt = 1'b1;
    cyc(1, 1, 0, e, "ecall HALT0");
    cyc(1, 1, 0, e, "ecall HALT1");
    RSTn = 1'b0;
    cyc(1, 1, 0, '0, "halt reset");
    RSTn = 1'b1;

    // unknown opcode 0x7F
    fetch(32'h0000007F, "ill");
    e = o_st(3'd5); e.halt = 1'b1; e.illegal = 1'b1;
    cyc(1, 1, 0, e, "ill HALT0");
    cyc(1, 1, 0, e, "ill HALT1");
    RSTn = 1'b0;
    cyc(1, 1, 0, '0, "ill reset");
    RSTn = 1'b1;
    cyc(1, 1, 0, o_if(1'b1), "post-reset IF");

    stim_done = 1'b1;
  end

  // Monitor: compare the DUT outputs against the queued expectation each cycle
  initial begin : monitor
    out_t  act;
    out_t  ex;
    string nm;
    int    idle;
    idle = 0;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        nm = name_q.pop_front();
        act = {state, halt, illegal, imem_req, ir_we, pc_we, pc_sel, tgt_we,
               a_sel, b_sel, is_sign, alu_control, dmem_re, dmem_we, rf_we, wb_sel};
        n_vec++;
        if (act !== ex) begin
          n_err++;
          $display("FAIL %s: outputs got %h want %h (state got %0d want %0d)",
                   nm, act, ex, act.state, ex.state);
        end
      end else if (stim_done) begin
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end else begin
        idle++;
        if (idle > 50) begin
          n_err++;
          $display("FAIL stimulus timeout: got idle %0d want <= 50", idle);
          $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
          $finish;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control FSM for the multicycle RV32I datapath built around the shared ALU. Sequences each instruction through IF/ID/EX/MEM/WB, drives ALU operand selects and alu_control, and strobes IR/PC/RF/target writes. Handshakes with instruction and data memory, stalling on ready. Halts on ECALL or an illegal opcode.

Parameters:
RESET_STATE, 3'd0, state entered on reset (IF)
ECALL_WORD, 32'h00000073, instruction word that halts the core

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  reset, synchronous, active-low
instr  in  32  IR contents; valid from ID onward
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access completes this cycle
alu_zero  in  1  alu_result == 0
imem_req  out  1  instruction fetch request
ir_we  out  1  latch instruction into IR
pc_we  out  1  update PC
pc_sel  out  1  0: PC+4, 1: target register
tgt_we  out  1  latch alu_result into target register
a_sel  out  2  ALU A: 0 RF_RD1, 1 PC, 2 zero
b_sel  out  1  ALU B: 0 RF_RD2, 1 imm
is_sign  out  1  signed compare/add
alu_control  out  5  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 JALR
dmem_re  out  1  load request
dmem_we  out  1  store request
rf_we  out  1  register-file write
wb_sel  out  2  0 ALU result, 1 load data, 2 PC+4
halt  out  1  core halted (sticky)
illegal  out  1  halt caused by an unknown opcode (sticky)
state  out  3  0 IF, 1 ID, 2 EX, 3 MEM, 4 WB, 5 HALT

Behaviour:
- state, halt and illegal are registered. All other outputs are combinational from state, instr and the ready inputs.
- While RSTn is low at a clock edge: state=IF, halt=0, illegal=0. Every output is forced to 0 while RSTn is low. Reset mid-instruction aborts it with no PC or RF write.
- IF: imem_req=1 and stay in IF. When imem_ready=1: ir_we=1, go to ID.
- ID: a_sel=1, b_sel=1, ADD, tgt_we=1 (target = PC+imm).
  - JAL, LUI, AUIPC go to WB.
  - instr==ECALL_WORD goes to HALT.
  - Unknown opcode goes to HALT with illegal=1.
  - All other opcodes go to EX.
- EX, OP: a_sel=0, b_sel=0. funct3 decode: 000 ADD, or SUB if funct7[5]; 001 SLL; 010 SLT, is_sign=1; 011 SLT, is_sign=0; 100 XOR; 101 SRL, or SRA if funct7[5]; 110 OR; 111 AND. Next state WB.
- EX, OP-IMM: same decode with b_sel=1. funct7[5] is honoured only for funct3=101. Next state WB.
- EX, LOAD/STORE: a_sel=0, b_sel=1, ADD. Next state MEM.
- EX, BRANCH: a_sel=0, b_sel=0.
  - BEQ/BNE use SUB. BLT/BGE use SLT with is_sign=1. BLTU/BGEU use SLT with is_sign=0.
  - taken: BEQ alu_zero; BNE !alu_zero; BLT/BLTU !alu_zero; BGE/BGEU alu_zero.
  - pc_we=1, pc_sel=taken. Next state IF.
- EX, JALR: a_sel=0, b_sel=1, alu_control=9, tgt_we=1. Next state WB.
- MEM: dmem_re (load) or dmem_we (store) is held until dmem_ready=1.
  - Load goes to WB on ready.
  - Store asserts pc_we=1, pc_sel=0 in the ready cycle, then goes to IF.
- WB: rf_we=1 and pc_we=1 for one cycle, then IF.
  - OP/OP-IMM: wb_sel=0, pc_sel=0.
  - LOAD: wb_sel=1, pc_sel=0.
  - JAL/JALR: wb_sel=2, pc_sel=1.
  - LUI: a_sel=2, b_sel=1, ADD, wb_sel=0, pc_sel=0.
  - AUIPC: a_sel=1, b_sel=1, ADD, wb_sel=0, pc_sel=0.
- Cycles per instruction with ready tied high: branch 3; JAL/LUI/AUIPC 3; R/I-ALU 4; JALR 4; store 4; load 5. Each ready-low cycle adds one.
- HALT is absorbing until reset. In HALT all strobes are 0 and halt=1.
- Exactly one pc_we pulse per retired instruction. tgt_we is never asserted in the same cycle as pc_we.

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0].
  - cycle_cnt increments every non-HALT cycle.
  - instret_cnt increments on each pc_we.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports absent, no counter logic.

Test Plan:
- Reset held 2 cycles, then released with imem_ready=1 -> all outputs 0 during reset; state=IF, imem_req=1 in the first cycle after release.
- add x3,x1,x2 (0x002081B3), imem_ready=1 -> IF, ID, EX, WB (4 cycles). In EX: alu_control=0, a_sel=0, b_sel=0. In WB: rf_we=1, wb_sel=0, pc_we=1, pc_sel=0.
- lw x5,0(x1) (0x0000A283), dmem_ready low 3 cycles -> dmem_re held 4 MEM cycles, then WB with wb_sel=1; 8 cycles total.
- beq x1,x2,8 (0x00208463) -> alu_zero=1 gives pc_we=1, pc_sel=1 in EX. Repeat with alu_zero=0 -> pc_sel=0. rf_we stays 0 throughout.
- jal x1,16 (0x010000EF) -> ID tgt_we=1; WB rf_we=1, wb_sel=2, pc_sel=1. sw x5,4(x1) (0x0050A223) -> dmem_we=1 in MEM, no rf_we.
- ecall (0x00000073) -> HALT, halt=1, no further imem_req. Opcode 0x7F -> halt=1, illegal=1. RSTn low for 1 cycle -> state=IF, halt=0, illegal=0.
